// File: rtl/multisim_client_pkg.sv
// Shared types for the multisim pull client, plus the behavioural server model that
// stands in for the C side of multisim_client_start / multisim_client_pull_packed.
package multisim_client_pkg;

    typedef enum logic {
        POLL    = 1'b0,
        BACKOFF = 1'b1
    } poll_state_e;

    localparam int unsigned MAX_WIDTH = 1024;

    function automatic int unsigned level_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct {
        string                 name;
        logic [MAX_WIDTH-1:0]  word;
    } server_word_t;

    // Words posted per server name, oldest first; call/hit tallies keyed by name.
    server_word_t server_q[$];
    string        runtime_dir[string];
    int unsigned  pull_calls[string];
    int unsigned  pull_hits[string];
    int unsigned  start_calls[string];

    function automatic int unsigned get_calls(input string name);
        return pull_calls.exists(name) ? pull_calls[name] : 0;
    endfunction

    function automatic int unsigned get_hits(input string name);
        return pull_hits.exists(name) ? pull_hits[name] : 0;
    endfunction

    function automatic int unsigned get_starts(input string name);
        return start_calls.exists(name) ? start_calls[name] : 0;
    endfunction

    function automatic void multisim_client_start(input string dir, input string name);
        if (!start_calls.exists(name)) begin
            start_calls[name] = 1;
            runtime_dir[name] = dir;
        end
    endfunction

    function automatic void multisim_server_post(input string name, input logic [MAX_WIDTH-1:0] word);
        server_word_t e;
        e.name = name;
        e.word = word;
        server_q.push_back(e);
    endfunction

    function automatic int multisim_client_pull_packed(input string name,
                                                       output logic [MAX_WIDTH-1:0] word,
                                                       input int unsigned width);
        logic [MAX_WIDTH-1:0] mask;
        mask = '1;
        if (width < MAX_WIDTH) mask = ~({MAX_WIDTH{1'b1}} << width);
        word = '0;
        pull_calls[name] = get_calls(name) + 1;
        for (int unsigned k = 0; k < server_q.size(); k++) begin
            if (server_q[k].name == name) begin
                word = server_q[k].word & mask;
                server_q.delete(k);
                pull_hits[name] = get_hits(name) + 1;
                return 1;
            end
        end
        return 0;
    endfunction

endpackage

// File: rtl/multisim_client_pull_buffered_fifo.sv
// Per-channel synchronous FIFO; head is raw storage, the caller gates it with vld.
module multisim_fifo
    import multisim_client_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 push,
    input  logic [DATA_WIDTH-1:0]                push_data,
    input  logic                                 pop,
    output logic [DATA_WIDTH-1:0]                head,
    output logic                                 vld,
    output logic [level_width(FIFO_DEPTH)-1:0]   level
);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LW = level_width(FIFO_DEPTH);
    localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr, wr_ptr;
    logic                  do_push, do_pop;

    assign vld     = (level != '0);
    assign do_pop  = pop && vld;
    assign do_push = push && (level < FULL);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

endmodule

// File: rtl/multisim_client_pull_buffered.sv
// Multi-channel pull client: each channel polls its server into a prefetch FIFO,
// with an optional idle backoff after an empty poll.
module multisim_client_pull_buffered
    import multisim_client_pkg::*;
#(
    parameter string SERVER_RUNTIME_DIRECTORY = "../output_top",
    parameter int    DATA_WIDTH               = 64,
    parameter int    NUM_CHANNELS             = 1,
    parameter int    FIFO_DEPTH               = 4,
    parameter int    BACKOFF_CYCLES           = 0
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  string                                         server_name,
    input  logic [NUM_CHANNELS-1:0]                       data_rdy,
    output logic [NUM_CHANNELS-1:0]                       data_vld,
    output logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]       data,
    output logic [NUM_CHANNELS-1:0][$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int unsigned   LW   = level_width(FIFO_DEPTH);
    localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        string                 chan_name;
        poll_state_e           state, state_n;
        logic [7:0]            cnt, cnt_n;
        logic                  started, poll_en;
        logic                  stage_vld;
        logic [DATA_WIDTH-1:0] stage_word, fifo_head;
        logic                  fifo_vld, fifo_push, fifo_pop;
        logic [LW-1:0]         fifo_cnt, level;

        always_comb begin
            if (NUM_CHANNELS == 1) chan_name = server_name;
            else                   chan_name = $sformatf("%s_%0d", server_name, i);
        end

        // A freshly pulled word sits in the stage register so it is visible right after
        // the pulling edge; it drains into the FIFO next edge unless popped directly.
        assign level         = fifo_cnt + LW'(stage_vld);
        assign fifo_pop      = data_rdy[i] & fifo_vld;
        assign fifo_push     = stage_vld & ~(data_rdy[i] & ~fifo_vld);
        assign data_vld[i]   = fifo_vld | stage_vld;
        assign data[i]       = fifo_vld ? fifo_head : (stage_vld ? stage_word : '0);
        assign fifo_level[i] = level;

        always_comb begin
            state_n = state;
            cnt_n   = cnt;
            poll_en = 1'b0;
            case (state)
                POLL: poll_en = (level < FULL);
                BACKOFF: begin
                    cnt_n = (cnt == '0) ? '0 : cnt - 8'd1;
                    if (cnt_n == '0) state_n = POLL;
                end
                default: state_n = POLL;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin : p_poll
            logic [MAX_WIDTH-1:0] rx;
            int                   rc;
            if (!rst_n) begin
                state      <= POLL;
                cnt        <= '0;
                started    <= 1'b0;
                stage_vld  <= 1'b0;
                stage_word <= '0;
            end else begin
                if (!started) begin
                    multisim_client_start(SERVER_RUNTIME_DIRECTORY, chan_name);
                    started <= 1'b1;
                end
                state     <= state_n;
                cnt       <= cnt_n;
                stage_vld <= 1'b0;
                if (poll_en) begin
                    rc = multisim_client_pull_packed(chan_name, rx, DATA_WIDTH);
                    if ((rc & 1) != 0) begin
                        stage_vld  <= 1'b1;
                        stage_word <= DATA_WIDTH'(rx);
                    end else if (BACKOFF_CYCLES > 0) begin
                        state <= BACKOFF;
                        cnt   <= 8'(BACKOFF_CYCLES);
                    end
                end
            end
        end

        multisim_fifo #(
            .DATA_WIDTH(DATA_WIDTH),
            .FIFO_DEPTH(FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (fifo_push),
            .push_data (stage_word),
            .pop       (fifo_pop),
            .head      (fifo_head),
            .vld       (fifo_vld),
            .level     (fifo_cnt)
        );
    end

endmodule

// File: tb/tb_multisim_client_pull_buffered.sv
// Directed bench: single-channel client (no backoff) and two-channel client (backoff 3).
module tb_multisim_client_pull_buffered;
    import multisim_client_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    string name_a = "srvA";
    string name_b = "srvB";

    logic [0:0]       rdy_a = '0;
    logic [0:0]       vld_a;
    logic [0:0][15:0] data_a;
    logic [0:0][2:0]  lvl_a;
    logic [1:0]       rdy_b = '0;
    logic [1:0]       vld_b;
    logic [1:0][7:0]  data_b;
    logic [1:0][2:0]  lvl_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multisim_client_pull_buffered #(
        .SERVER_RUNTIME_DIRECTORY("../output_top"),
        .DATA_WIDTH(16), .NUM_CHANNELS(1), .FIFO_DEPTH(4), .BACKOFF_CYCLES(0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .server_name(name_a),
        .data_rdy(rdy_a), .data_vld(vld_a), .data(data_a), .fifo_level(lvl_a)
    );

    multisim_client_pull_buffered #(
        .SERVER_RUNTIME_DIRECTORY("../output_top"),
        .DATA_WIDTH(8), .NUM_CHANNELS(2), .FIFO_DEPTH(4), .BACKOFF_CYCLES(3)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .server_name(name_b),
        .data_rdy(rdy_b), .data_vld(vld_b), .data(data_b), .fifo_level(lvl_b)
    );

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL reset_vld_a: got %b expected 0", vld_a); end
        checks++; if (data_a[0] !== 16'h0) begin errors++; $display("FAIL reset_data_a: got %h expected 0", data_a[0]); end
        checks++; if (lvl_a[0] !== 3'd0) begin errors++; $display("FAIL reset_lvl_a: got %0d expected 0", lvl_a[0]); end
        checks++; if (vld_b !== 2'b00) begin errors++; $display("FAIL reset_vld_b: got %b expected 00", vld_b); end
        checks++; if (get_calls("srvA") != 0) begin errors++; $display("FAIL reset_no_pull: got %0d expected 0", get_calls("srvA")); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (get_calls("srvA") != 1) begin errors++; $display("FAIL first_poll: got %0d expected 1", get_calls("srvA")); end
        checks++; if (get_starts("srvA") != 1) begin errors++; $display("FAIL start_a: got %0d expected 1", get_starts("srvA")); end
        checks++; if (get_starts("srvB_1") != 1) begin errors++; $display("FAIL start_b1: got %0d expected 1", get_starts("srvB_1")); end
    endtask

    task automatic test_stream();
        logic [15:0] exp_w [3] = '{16'h11, 16'h22, 16'h33};
        int unsigned c0 = get_calls("srvA");
        int unsigned h0 = get_hits("srvA");
        for (int k = 0; k < 3; k++) multisim_server_post("srvA", MAX_WIDTH'(exp_w[k]));
        rdy_a = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (vld_a !== 1'b1 || data_a[0] !== exp_w[k]) begin
                errors++; $display("FAIL stream_word[%0d]: got vld=%b data=%h expected vld=1 data=%h", k, vld_a, data_a[0], exp_w[k]);
            end
        end
        @(negedge clk);
        checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL stream_drained: got %b expected 0", vld_a); end
        checks++; if (get_calls("srvA") - c0 != 4) begin errors++; $display("FAIL stream_calls: got %0d expected 4", get_calls("srvA") - c0); end
        checks++; if (get_hits("srvA") - h0 != 3) begin errors++; $display("FAIL stream_hits: got %0d expected 3", get_hits("srvA") - h0); end
        rdy_a = 1'b0;
    endtask

    task automatic test_fill();
        int unsigned c0 = get_calls("srvA");
        int unsigned h0 = get_hits("srvA");
        for (int k = 0; k < 6; k++) multisim_server_post("srvA", MAX_WIDTH'(16'hA0 + k));
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++; if (lvl_a[0] !== 3'((k < 4) ? k + 1 : 4)) begin
                errors++; $display("FAIL fill_level[%0d]: got %0d expected %0d", k, lvl_a[0], (k < 4) ? k + 1 : 4);
            end
            checks++; if (vld_a !== 1'b1 || data_a[0] !== 16'hA0) begin
                errors++; $display("FAIL fill_hold[%0d]: got vld=%b data=%h expected vld=1 data=a0", k, vld_a, data_a[0]);
            end
        end
        checks++; if (get_calls("srvA") - c0 != 4) begin errors++; $display("FAIL fill_calls: got %0d expected 4", get_calls("srvA") - c0); end
        checks++; if (get_hits("srvA") - h0 != 4) begin errors++; $display("FAIL fill_hits: got %0d expected 4", get_hits("srvA") - h0); end
        rdy_a = 1'b1;
        for (int k = 1; k < 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++; if (get_calls("srvA") - c0 != 4) begin errors++; $display("FAIL full_edge_call: got %0d expected 4", get_calls("srvA") - c0); end
            end
            checks++; if (vld_a !== 1'b1 || data_a[0] !== 16'(16'hA0 + k)) begin
                errors++; $display("FAIL drain_word[%0d]: got vld=%b data=%h expected vld=1 data=%h", k, vld_a, data_a[0], 16'(16'hA0 + k));
            end
        end
        @(negedge clk);
        checks++; if (vld_a !== 1'b0 || lvl_a[0] !== 3'd0) begin
            errors++; $display("FAIL drain_empty: got vld=%b lvl=%0d expected vld=0 lvl=0", vld_a, lvl_a[0]);
        end
        rdy_a = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 10; k++) multisim_server_post("srvA", MAX_WIDTH'(16'hB0 + k));
        repeat (4) @(negedge clk);
        checks++; if (lvl_a[0] !== 3'd4) begin errors++; $display("FAIL b2b_full: got %0d expected 4", lvl_a[0]); end
        rdy_a = 1'b1;
        for (int k = 0; k < 10; k++) begin
            checks++; if (vld_a !== 1'b1 || data_a[0] !== 16'(16'hB0 + k)) begin
                errors++; $display("FAIL b2b_word[%0d]: got vld=%b data=%h expected vld=1 data=%h", k, vld_a, data_a[0], 16'(16'hB0 + k));
            end
            @(negedge clk);
        end
        checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b expected 0", vld_a); end
        rdy_a = 1'b0;
    endtask

    task automatic test_backoff();
        int unsigned prev = get_calls("srvB_0");
        int unsigned d;
        int          hit_edges[$];
        bool_wait: begin end
        rdy_b = 2'b00;
        for (int e = 0; e < 12; e++) begin
            @(negedge clk);
            d = get_calls("srvB_0") - prev;
            prev = get_calls("srvB_0");
            if (d != 0) hit_edges.push_back(e);
        end
        checks++; if (hit_edges.size() != 3) begin errors++; $display("FAIL backoff_count: got %0d expected 3", hit_edges.size()); end
        else begin
            checks++; if (hit_edges[1] - hit_edges[0] != 4 || hit_edges[2] - hit_edges[1] != 4) begin
                errors++; $display("FAIL backoff_period: got %0d,%0d expected 4,4", hit_edges[1] - hit_edges[0], hit_edges[2] - hit_edges[1]);
            end
        end
        d = 0;
        for (int t = 0; t < 8 && d == 0; t++) begin
            @(negedge clk);
            d = get_calls("srvB_0") - prev;
            prev = get_calls("srvB_0");
        end
        checks++; if (d != 1) begin errors++; $display("FAIL backoff_wait: got %0d calls expected 1", d); end
        multisim_server_post("srvB_0", MAX_WIDTH'(8'hC5));
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            d = get_calls("srvB_0") - prev;
            prev = get_calls("srvB_0");
            checks++; if (d != ((j == 4) ? 1 : 0) || vld_b[0] !== (j == 4)) begin
                errors++; $display("FAIL backoff_post[%0d]: got calls=%0d vld=%b expected calls=%0d vld=%b", j, d, vld_b[0], (j == 4) ? 1 : 0, j == 4);
            end
        end
        checks++; if (data_b[0] !== 8'hC5) begin errors++; $display("FAIL backoff_word: got %h expected c5", data_b[0]); end
    endtask

    task automatic test_channels();
        int unsigned h0 = get_hits("srvB_0");
        int          waited = 0;
        rdy_b = 2'b10;
        for (int k = 0; k < 6; k++) multisim_server_post("srvB_0", MAX_WIDTH'(8'hD0 + k));
        for (int k = 0; k < 8; k++) multisim_server_post("srvB_1", MAX_WIDTH'(8'hE0 + k));
        while (vld_b[1] !== 1'b1 && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        checks++; if (vld_b[1] !== 1'b1) begin errors++; $display("FAIL ch1_start_timeout: got vld=%b expected 1", vld_b[1]); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (vld_b[1] !== 1'b1 || data_b[1] !== 8'(8'hE0 + k)) begin
                errors++; $display("FAIL ch1_word[%0d]: got vld=%b data=%h expected vld=1 data=%h", k, vld_b[1], data_b[1], 8'(8'hE0 + k));
            end
            @(negedge clk);
        end
        checks++; if (vld_b[1] !== 1'b0) begin errors++; $display("FAIL ch1_drained: got %b expected 0", vld_b[1]); end
        checks++; if (lvl_b[0] !== 3'd4 || data_b[0] !== 8'hC5) begin
            errors++; $display("FAIL ch0_full: got lvl=%0d data=%h expected lvl=4 data=c5", lvl_b[0], data_b[0]);
        end
        checks++; if (get_hits("srvB_0") - h0 != 3) begin errors++; $display("FAIL ch0_hits: got %0d expected 3", get_hits("srvB_0") - h0); end
        rdy_b = 2'b00;
    endtask

    task automatic test_reset_mid();
        int unsigned c0;
        for (int k = 0; k < 3; k++) multisim_server_post("srvA", MAX_WIDTH'(16'h51 + k));
        repeat (3) @(negedge clk);
        checks++; if (lvl_a[0] !== 3'd3) begin errors++; $display("FAIL pre_reset_lvl: got %0d expected 3", lvl_a[0]); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (vld_a !== 1'b0 || lvl_a[0] !== 3'd0) begin
            errors++; $display("FAIL async_reset: got vld=%b lvl=%0d expected vld=0 lvl=0", vld_a, lvl_a[0]);
        end
        c0 = get_calls("srvA");
        multisim_server_post("srvA", MAX_WIDTH'(16'h77));
        repeat (2) @(negedge clk);
        checks++; if (get_calls("srvA") != c0) begin errors++; $display("FAIL reset_calls: got %0d expected %0d", get_calls("srvA"), c0); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (get_calls("srvA") - c0 != 1) begin errors++; $display("FAIL resume_poll: got %0d expected 1", get_calls("srvA") - c0); end
        checks++; if (vld_a !== 1'b1 || data_a[0] !== 16'h77 || lvl_a[0] !== 3'd1) begin
            errors++; $display("FAIL resume_word: got vld=%b data=%h lvl=%0d expected vld=1 data=0077 lvl=1", vld_a, data_a[0], lvl_a[0]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_fill();
        test_back_to_back();
        test_backoff();
        test_channels();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multisim_client_pull_buffered.md
MULTISIM_CLIENT_PULL_BUFFERED -- requirements
Module: multisim_client_pull_buffered

Interface
REQ-001 SHALL have parameter SERVER_RUNTIME_DIRECTORY, default "../output_top", runtime directory of the multisim server.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, payload bits per channel word (1..1024).
REQ-003 SHALL have parameter NUM_CHANNELS, default 1, independent pull channels (1..16).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, prefetch entries per channel (power of two, 2..64).
REQ-005 SHALL have parameter BACKOFF_CYCLES, default 0, idle cycles per channel after an empty poll (0..255).
REQ-006 SHALL have port clk  input  1  sole clock; all state on its rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 SHALL have port server_name  input  string  base server name; channel i uses server_name when NUM_CHANNELS==1, else server_name followed by "_" and decimal i.
REQ-009 SHALL have port data_rdy  input  NUM_CHANNELS  per-channel consumer ready.
REQ-010 SHALL have port data_vld  output  NUM_CHANNELS  per-channel head-of-FIFO valid.
REQ-011 SHALL have port data  output  NUM_CHANNELS x DATA_WIDTH  per-channel head-of-FIFO word.
REQ-012 SHALL have port fifo_level  output  NUM_CHANNELS x ($clog2(FIFO_DEPTH)+1)  per-channel occupancy.

Function
REQ-013 SHALL call multisim_client_start once per channel at time zero with SERVER_RUNTIME_DIRECTORY and the channel name.
REQ-014 SHALL, per channel, run states POLL and BACKOFF; reset state POLL.
REQ-015 In POLL at a clk edge with rst_n high and level < FIFO_DEPTH, SHALL call multisim_client_pull_packed exactly once for that channel with width DATA_WIDTH.
REQ-016 SHALL push the returned word when bit 0 of the DPI return is 1; SHALL discard it otherwise.
REQ-017 SHALL, on an empty poll with BACKOFF_CYCLES>0, enter BACKOFF, load counter with BACKOFF_CYCLES, and make no DPI call until counter reaches 0, then return to POLL.
REQ-018 SHALL remain in POLL after a successful poll or when BACKOFF_CYCLES==0.
REQ-019 SHALL NOT call DPI when level == FIFO_DEPTH at the edge, even if a pop occurs that edge (no pop credit).
REQ-020 SHALL assert data_vld[i] iff level[i] > 0; data[i] equals the oldest unpopped word.
REQ-021 SHALL pop on a clk edge where data_vld[i] and data_rdy[i] are both 1.
REQ-022 Word pulled at edge N SHALL appear on data_vld/data after edge N (one-edge latency into empty FIFO).
REQ-023 Simultaneous push and pop SHALL leave level unchanged and preserve order.
REQ-024 Read/write pointers SHALL wrap modulo FIFO_DEPTH; level SHALL never exceed FIFO_DEPTH nor underflow.
REQ-025 data SHALL hold value while data_vld high and data_rdy low.
REQ-026 Channels SHALL be fully independent; one channel's stall SHALL NOT affect another's polling.

Reset
REQ-027 While rst_n low: data_vld=0, data=0, fifo_level=0, state POLL, backoff counter 0, no DPI pull calls.
REQ-028 rst_n assertion mid-operation SHALL discard all buffered words immediately (asynchronous); first poll occurs at first rising clk edge with rst_n high.

Structure
REQ-029 Package multisim_client_pkg SHALL hold the poll-state enum (POLL, BACKOFF) and the level-width function.
REQ-030 Sub-module multisim_fifo (sync FIFO, DATA_WIDTH/FIFO_DEPTH parameters, push/pop/level, async active-low reset) SHALL be instantiated once per channel.
REQ-031 DPI calls and state machine SHALL reside in a generate loop over channels in the top module.

Verification
REQ-032 NUM_CHANNELS=1, server supplies 0x11,0x22,0x33, data_rdy=1 -> data_vld high three consecutive cycles, data 0x11,0x22,0x33 in order.
REQ-033 FIFO_DEPTH=4, data_rdy=0, server supplies 6 words -> level saturates at 4, exactly 4 successful DPI calls, no pulls while full; release rdy -> 6 words delivered in order.
REQ-034 BACKOFF_CYCLES=3, server empty -> DPI pull calls exactly every 4th cycle; word posted mid-backoff delivered after next POLL.
REQ-035 Level=4, data_rdy=1 continuously -> no DPI call on full edge; steady throughput one word per cycle after first refill, order preserved.
REQ-036 NUM_CHANNELS=2, ch0 rdy=0, ch1 rdy=1, both servers supplying -> ch1 streams unaffected while ch0 fills to FIFO_DEPTH.
REQ-037 rst_n low for 2 cycles with level=3 -> data_vld and fifo_level 0 immediately, buffered words lost, no DPI calls during reset, polling resumes first edge after release.
